uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  Sequences the UART receive path to load a program image into instruction/data RAM.
//  Consumes received bytes (byte + one-cycle valid strobe) and parses a 2-byte word-count header.
//  Packs payload bytes into 32-bit words and issues one memory write per word at incrementing addresses.
//  Holds the CPU in reset while a load is in progress; a gap timeout aborts a stalled transfer.
// PARAMETERS
//  ADDR_W     14          word-address width of the target RAM
//  BASE_ADDR  0           first word address written
//  TIMEOUT    10_000_000  max sys_clk cycles between bytes while receiving (100 ms at 100 MHz)
// PORTS
//  sys_clk    in   1       system clock; all state changes on posedge
//  sys_rst_n  in   1       asynchronous, active-low reset
//  start      in   1       one-cycle pulse: begin a load (ignored while busy)
//  rx_data    in   8       received byte, valid only when rx_valid=1
//  rx_valid   in   1       one-cycle strobe per received byte
//  mem_we     out  1       one-cycle write strobe to RAM
//  mem_addr   out  ADDR_W  word address of current write
//  mem_wdata  out  32      word being written
//  busy       out  1       load in progress (state != IDLE/DONE/ERR)
//  cpu_hold   out  1       =busy; drives CPU reset request
//  done       out  1       sticky: last load completed; cleared by start
//  err        out  1       sticky: last load aborted; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, cpu_hold=0, done=0, err=0,
//   byte index=0, word count=0, timeout counter=0.
//  States: IDLE -> LEN_LO -> LEN_HI -> DATA <-> WRITE -> DONE | ERR; DONE/ERR return to LEN_LO on start.
//  IDLE/DONE/ERR: start -> LEN_LO, clear done/err, mem_addr=BASE_ADDR, timeout counter=0.
//  LEN_LO: rx_valid -> count[7:0]=rx_data, go LEN_HI.
//  LEN_HI: rx_valid -> count[15:8]=rx_data; if count==0 -> DONE; if count > 2**ADDR_W -> ERR;
//   else -> DATA.
//  DATA: rx_valid -> byte lane idx gets rx_data (little-endian: 1st byte -> [7:0], 4th byte -> [31:24]);
//   idx increments mod 4; on the 4th byte -> WRITE.
//  WRITE: exactly one cycle, mem_we=1 with mem_wdata/mem_addr stable;
//   remaining word count decrements; if count reaches 0 -> DONE; else -> DATA.
//   mem_addr increments on the cycle after the strobe, wrapping at 2**ADDR_W.
//  rx_valid arriving in the WRITE cycle is not lost; it is captured as byte 0 of the next word.
//  Write latency: mem_we asserts the cycle after the rx_valid of a word's 4th byte.
//  Timeout: counter resets on every rx_valid and on entry to LEN_LO; counts in LEN_LO/LEN_HI/DATA.
//   Reaching TIMEOUT -> ERR; a partial word is discarded and never written.
//  DONE: done=1, busy=0. ERR: err=1, busy=0. done and err are never both 1.
//  rx_valid is ignored in IDLE, DONE and ERR.
//  start is ignored while busy; start and rx_valid in the same cycle in IDLE: start wins, byte dropped.
//  Async reset mid-load: immediate return to reset values; no further mem_we.
// TESTING
//  1. start, bytes 01 00 78 56 34 12 -> one mem_we, addr=BASE_ADDR, wdata=32'h12345678, then done=1.
//  2. count=3, 12 payload bytes -> 3 writes at BASE..BASE+2; cpu_hold=1 throughout, 0 at done.
//  3. header 00 00 -> done=1 with no mem_we; header exceeding 2**ADDR_W -> err=1, no mem_we.
//  4. count=2, send 6 bytes, then idle > TIMEOUT -> exactly 1 write, err=1, busy=0.
//  5. rx_valid coincident with the WRITE cycle -> byte lands in lane [7:0] of the next word.
//  6. Assert sys_rst_n=0 mid-word -> all outputs at reset values next cycle; start while busy is ignored.

Source files
------------

// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader_if
//  Brief    : Byte-stream input, RAM write port and status signals of the
//             UART boot loader, bundled for connection between loader and
//             its environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_boot_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    // Loader side: consumes bytes, drives the RAM write port and status
    modport master (
        input  start, rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err
    );

    // Environment side: UART receiver / host control and RAM
    modport slave (
        output start, rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err
    );
endinterface
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Brief    : Parses a 2-byte little-endian word-count header from a received
//             byte stream, packs payload bytes into 32-bit words and writes
//             them to RAM at incrementing addresses. Holds the CPU in reset
//             while loading; an inter-byte gap timeout aborts the transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 10_000_000
) (
    input  wire                 sys_clk,
    input  wire                 sys_rst_n,
    uart_boot_loader_if.master  bus
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [31:0]       c_MAX_WORDS = 32'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_count;
    logic [1:0]        r_idx;
    logic [23:0]       r_word;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_idle_like;
    logic              w_start_acc;
    logic              w_counting;
    logic              w_tmo_hit;
    logic              w_take;
    logic [15:0]       w_len;
    logic              w_len_big;

    // start is only honoured when no load is running
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_start_acc = bus.start && w_idle_like;
    assign w_counting  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
    // A byte arriving during the write cycle already belongs to the next word
    assign w_take      = bus.rx_valid && ((r_state == S_DATA) || (r_state == S_WRITE));
    assign w_len       = {bus.rx_data, r_count[7:0]};
    assign w_len_big   = {16'd0, w_len} > c_MAX_WORDS;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (bus.rx_valid)     w_state_nxt = S_LEN_HI;
                else if (w_tmo_hit)   w_state_nxt = S_ERR;
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    if (w_len == 16'd0)  w_state_nxt = S_DONE;
                    else if (w_len_big)  w_state_nxt = S_ERR;
                    else                 w_state_nxt = S_DATA;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (r_idx == 2'd3) w_state_nxt = S_WRITE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                // r_count is the number of words left including this one
                if (r_count == 16'd1) w_state_nxt = S_DONE;
                else                  w_state_nxt = S_DATA;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Header capture, remaining-word count and write address
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_count <= 16'd0;
            r_addr  <= c_BASE;
        end else begin
            if (w_start_acc) begin
                r_addr <= c_BASE;
            end else if (r_state == S_WRITE) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_state == S_LEN_LO && bus.rx_valid) begin
                r_count[7:0] <= bus.rx_data;
            end else if (r_state == S_LEN_HI && bus.rx_valid) begin
                r_count[15:8] <= bus.rx_data;
            end else if (r_state == S_WRITE) begin
                r_count <= r_count - 16'd1;
            end
        end
    end

    // Little-endian byte packing; the completed word is latched for the write
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx   <= 2'd0;
            r_word  <= 24'd0;
            r_wdata <= 32'd0;
        end else if (w_start_acc) begin
            r_idx <= 2'd0;
        end else if (w_take) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_word[7:0]   <= bus.rx_data;
                2'd1:    r_word[15:8]  <= bus.rx_data;
                2'd2:    r_word[23:16] <= bus.rx_data;
                default: r_wdata       <= {bus.rx_data, r_word};
            endcase
        end
    end

    // Inter-byte gap counter: cleared by any byte and on load start
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tmo <= '0;
        end else if (w_start_acc || bus.rx_valid) begin
            r_tmo <= '0;
        end else if (w_counting) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = w_counting || (r_state == S_WRITE);
    assign bus.cpu_hold  = bus.busy;
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_boot_loader
//  Brief    : Directed self-checking bench for uart_boot_loader. Expected RAM
//             writes are queued as bytes are sent and compared against the
//             writes captured from the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 3;
    localparam int TIMEOUT   = 40;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              hold;
    } wr_t;

    logic sys_clk;
    logic sys_rst_n;
    int   tests;
    int   fails;
    wr_t  exp_q[$];
    wr_t  obs_q[$];

    uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_boot_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Capture every RAM write away from the active edge
    always @(negedge sys_clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata, hold: bus.cpu_hold});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        wr_t e;
        wr_t o;
        chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
            chk({tag, "_data"}, o.data, e.data);
            chk({tag, "_hold"}, 32'(o.hold), 32'(e.hold));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(b));
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_err"},  32'(bus.err), 32'(e));
    endtask

    // All stimulus tasks start and end on a falling edge
    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0]);
        idle(1);
        send_byte(n[15:8]);
        idle(1);
    endtask

    // Sends one word LSB first and queues its expected write
    task automatic send_word(input logic [31:0] w, input int gap, input int addr, input logic q);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gap > 0) idle(gap);
        end
        if (q) exp_q.push_back('{addr: ADDR_W'(addr), data: w, hold: 1'b1});
    endtask

    initial begin
        logic [31:0] words [3];
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h0BADF00D;
        words[2] = 32'hCAFEBABE;
        tests = 0;
        fails = 0;
        sys_rst_n    = 1'b0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'(BASE_ADDR));
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        idle(2);

        // One-word load
        pulse_start();
        send_header(16'd1);
        send_word(32'h12345678, 1, BASE_ADDR, 1'b1);
        idle(4);
        check_status("t1", 1'b0, 1'b1, 1'b0);
        check_writes("t1");

        // Three words, CPU held during all writes
        pulse_start();
        chk("t2_done_clr", 32'(bus.done), 32'd0);
        send_header(16'd3);
        chk("t2_hold_hdr", 32'(bus.cpu_hold), 32'd1);
        for (int i = 0; i < 3; i++) send_word(words[i], 2, BASE_ADDR + i, 1'b1);
        idle(4);
        check_status("t2", 1'b0, 1'b1, 1'b0);
        check_writes("t2");

        // Zero-length header completes with no writes
        pulse_start();
        send_header(16'd0);
        idle(3);
        check_status("t3z", 1'b0, 1'b1, 1'b0);
        check_writes("t3z");

        // Header one above the RAM depth is rejected
        pulse_start();
        send_header(16'd17);
        idle(3);
        check_status("t3big", 1'b0, 1'b0, 1'b1);
        check_writes("t3big");

        // Gap timeout after a partial second word
        pulse_start();
        chk("t4_err_clr", 32'(bus.err), 32'd0);
        send_header(16'd2);
        send_word(32'hA1B2C3D4, 1, BASE_ADDR, 1'b1);
        send_byte(8'h55);
        idle(1);
        send_byte(8'h66);
        idle(TIMEOUT + 10);
        check_status("t4", 1'b0, 1'b0, 1'b1);
        check_writes("t4");

        // Fresh load after the abort: stale partial bytes must not leak in
        pulse_start();
        send_header(16'd1);
        send_word(32'h99887766, 1, BASE_ADDR, 1'b1);
        idle(4);
        check_status("t4b", 1'b0, 1'b1, 1'b0);
        check_writes("t4b");

        // Back-to-back bytes: 5th byte arrives during the write cycle
        pulse_start();
        send_header(16'd2);
        send_word(32'h04030201, 0, BASE_ADDR, 1'b1);
        send_word(32'h08070605, 0, BASE_ADDR + 1, 1'b1);
        idle(4);
        check_status("t5", 1'b0, 1'b1, 1'b0);
        check_writes("t5");

        // Full-depth header accepted; start while busy ignored; reset mid-word
        pulse_start();
        send_header(16'd16);
        check_status("t6_busy", 1'b1, 1'b0, 1'b0);
        pulse_start();
        send_word(32'h5A5AC3C3, 1, BASE_ADDR, 1'b1);
        idle(2);
        check_writes("t6_ign");
        send_byte(8'hEE);
        send_byte(8'hFF);
        idle(0);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("t6_rst_we",    32'(bus.mem_we), 32'd0);
        chk("t6_rst_addr",  32'(bus.mem_addr), 32'(BASE_ADDR));
        chk("t6_rst_wdata", bus.mem_wdata, 32'd0);
        check_status("t6_rst", 1'b0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        idle(4);
        check_writes("t6_nowr");

        // start and rx_valid together in IDLE: byte dropped, load proceeds
        bus.start    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h02;
        @(negedge sys_clk);
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        send_header(16'd1);
        send_word(32'h0F1E2D3C, 1, BASE_ADDR, 1'b1);
        idle(4);
        check_status("t7", 1'b0, 1'b1, 1'b0);
        check_writes("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
